// File: rtl/sha_ctrl_pkg.sv
// rtl/sha_ctrl_pkg.sv - shared state encoding and core bus constants for the nonce scheduler
package sha_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        KICK,
        WAIT,
        CHECK,
        DONE,
        ERR
    } state_t;

    localparam logic [4:0]  CORE_START_ADDR = 5'd16;
    localparam logic [31:0] CORE_START_WORD = 32'hFFFF_FFFF;
    localparam int          NUM_BLOCK_WORDS = 16;

endpackage

// File: rtl/digest_lt_cmp.sv
// rtl/digest_lt_cmp.sv - combinational 256-bit unsigned less-than, bit 255 most significant
module digest_lt_cmp (
    input  logic [255:0] a,
    input  logic [255:0] b,
    output logic         lt
);

    assign lt = (a < b);

endmodule

// File: rtl/sha_nonce_scheduler.sv
// rtl/sha_nonce_scheduler.sv - drives the SHA-256 core over a nonce range and stops on a digest below target
module sha_nonce_scheduler
    import sha_ctrl_pkg::*;
#(
    parameter int NONCE_WORD = 3,
    parameter int WAIT_MAX   = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [511:0] block_in,
    input  logic [255:0] target,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    output logic         core_chipselect,
    output logic         core_write,
    output logic [4:0]   core_address,
    output logic [31:0]  core_writedata,
    input  logic         core_hashdone,
    input  logic [255:0] core_digest,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic         error,
    output logic [31:0]  nonce_out,
    output logic [31:0]  hash_count
);

    localparam logic [3:0] NONCE_IDX = 4'(NONCE_WORD);
    localparam logic [7:0] WAIT_LIM  = 8'(WAIT_MAX);
    localparam logic [3:0] LAST_WORD = 4'(NUM_BLOCK_WORDS - 1);

    state_t            state, state_nx;
    logic [15:0][31:0] block_q;
    logic [255:0]      target_q;
    logic [255:0]      digest_q;
    logic [31:0]       nonce;
    logic [31:0]       nonce_end_q;
    logic [3:0]        word_idx;
    logic [7:0]        wait_cnt;
    logic              hashdone_q;
    logic              hd_rise;
    logic              hit;
    logic              last_nonce;
    logic              start_ok;
    logic              range_empty;

    digest_lt_cmp u_cmp (
        .a  (digest_q),
        .b  (target_q),
        .lt (hit)
    );

    // A level-style hashdone left high from the previous nonce must not count again.
    assign hd_rise     = core_hashdone && !hashdone_q;
    assign last_nonce  = (nonce == nonce_end_q);
    assign range_empty = (nonce_start > nonce_end);
    assign start_ok    = start && !abort && (state == IDLE || state == DONE || state == ERR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE, DONE, ERR: if (start) state_nx = range_empty ? DONE : LOAD;
                LOAD:            if (word_idx == LAST_WORD) state_nx = KICK;
                KICK:            state_nx = WAIT;
                WAIT: begin
                    if (hd_rise)                    state_nx = CHECK;
                    else if (wait_cnt == WAIT_LIM)  state_nx = ERR;
                end
                CHECK:           state_nx = (hit || last_nonce) ? DONE : LOAD;
                default:         state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        busy            = 1'b0;
        core_chipselect = 1'b0;
        core_write      = 1'b0;
        core_address    = 5'd0;
        core_writedata  = 32'd0;
        case (state)
            LOAD: begin
                busy            = 1'b1;
                core_chipselect = 1'b1;
                core_write      = 1'b1;
                core_address    = {1'b0, word_idx};
                core_writedata  = (word_idx == NONCE_IDX) ? nonce : block_q[LAST_WORD - word_idx];
            end
            KICK: begin
                busy            = 1'b1;
                core_chipselect = 1'b1;
                core_write      = 1'b1;
                core_address    = CORE_START_ADDR;
                core_writedata  = CORE_START_WORD;
            end
            WAIT: begin
                busy            = 1'b1;
                core_chipselect = 1'b1;
            end
            CHECK:   busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            block_q     <= '0;
            target_q    <= '0;
            digest_q    <= '0;
            nonce       <= '0;
            nonce_end_q <= '0;
            word_idx    <= '0;
            wait_cnt    <= '0;
            hashdone_q  <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            error       <= 1'b0;
            nonce_out   <= '0;
            hash_count  <= '0;
        end else begin
            hashdone_q <= core_hashdone;
            if (start_ok) begin
                block_q     <= block_in;
                target_q    <= target;
                nonce       <= nonce_start;
                nonce_end_q <= nonce_end;
                word_idx    <= '0;
                done        <= range_empty;
                found       <= 1'b0;
                error       <= 1'b0;
                hash_count  <= '0;
            end else if (!abort) begin
                case (state)
                    LOAD: word_idx <= word_idx + 4'd1;
                    KICK: wait_cnt <= '0;
                    WAIT: begin
                        if (hd_rise)                   digest_q <= core_digest;
                        else if (wait_cnt == WAIT_LIM) error    <= 1'b1;
                        else                           wait_cnt <= wait_cnt + 8'd1;
                    end
                    CHECK: begin
                        if (hash_count != 32'hFFFF_FFFF) hash_count <= hash_count + 32'd1;
                        nonce_out <= nonce;
                        // Terminating on nonce_end before incrementing keeps FFFFFFFF from wrapping to 0.
                        if (hit || last_nonce) begin
                            done  <= 1'b1;
                            found <= hit;
                        end else begin
                            nonce <= nonce + 32'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// tb/tb_sha_nonce_scheduler.sv - self-checking bench with a behavioural SHA core and sweep reference model
module tb_sha_nonce_scheduler;

    localparam int NW   = 3;
    localparam int WMAX = 255;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         abort_auto = 1'b0;
    logic [511:0] block_in = '0;
    logic [255:0] target = '0;
    logic [31:0]  nonce_start = '0;
    logic [31:0]  nonce_end = '0;
    logic         core_chipselect, core_write;
    logic [4:0]   core_address;
    logic [31:0]  core_writedata;
    logic         core_hashdone = 1'b0;
    logic [255:0] core_digest = '0;
    logic         busy, done, found, error;
    logic [31:0]  nonce_out, hash_count;

    int errors = 0;
    int checks = 0;

    logic [31:0] cur_w [16];
    logic [31:0] mem [16];
    logic [36:0] wq [$];
    logic [36:0] eq [$];
    int hd_cnt = 0;
    int hd_seen = 0;
    int abort_n = 0;
    bit hd_en = 1'b1;

    always #5 clk = ~clk;

    sha_nonce_scheduler #(.NONCE_WORD(NW), .WAIT_MAX(WMAX)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort | abort_auto),
        .block_in        (block_in),
        .target          (target),
        .nonce_start     (nonce_start),
        .nonce_end       (nonce_end),
        .core_chipselect (core_chipselect),
        .core_write      (core_write),
        .core_address    (core_address),
        .core_writedata  (core_writedata),
        .core_hashdone   (core_hashdone),
        .core_digest     (core_digest),
        .busy            (busy),
        .done            (done),
        .found           (found),
        .error           (error),
        .nonce_out       (nonce_out),
        .hash_count      (hash_count)
    );

    function automatic logic [255:0] digest_of(input logic [31:0] w0, input logic [31:0] wn);
        return {8{~(wn ^ w0)}};
    endfunction

    // Behavioural core: captures writes, answers 65 cycles after the start write.
    initial begin
        forever begin
            @(negedge clk);
            abort_auto    = 1'b0;
            core_hashdone = 1'b0;
            if (hd_cnt > 0) begin
                hd_cnt = hd_cnt - 1;
                if (hd_cnt == 0) begin
                    core_hashdone = 1'b1;
                    core_digest   = digest_of(mem[0], mem[NW]);
                    hd_seen       = hd_seen + 1;
                    if (hd_seen == abort_n) abort_auto = 1'b1;
                end
            end
            if (core_chipselect && core_write) begin
                wq.push_back({core_address, core_writedata});
                if (core_address < 5'd16) mem[core_address[3:0]] = core_writedata;
                else if (hd_en) hd_cnt = 65;
            end
        end
    end

    task automatic model_sweep(input logic [255:0] tgt, input logic [31:0] s, input logic [31:0] e,
                               output bit f, output logic [31:0] nlast, output logic [31:0] cnt);
        eq.delete();
        f = 1'b0; nlast = '0; cnt = '0;
        for (longint n = longint'(s); n <= longint'(e); n++) begin
            for (int i = 0; i < 16; i++)
                eq.push_back({5'(i), (i == NW) ? 32'(n) : cur_w[i]});
            eq.push_back({5'd16, 32'hFFFF_FFFF});
            cnt   = cnt + 1;
            nlast = 32'(n);
            if (digest_of(cur_w[0], 32'(n)) < tgt) begin
                f = 1'b1;
                break;
            end
        end
    endtask

    task automatic kick(input logic [255:0] tgt, input logic [31:0] s, input logic [31:0] e);
        @(negedge clk);
        for (int i = 0; i < 16; i++) block_in[511 - 32*i -: 32] = cur_w[i];
        target = tgt; nonce_start = s; nonce_end = e;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        block_in = {16{$urandom}};
        target = {8{$urandom}};
        nonce_start = $urandom; nonce_end = $urandom;
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic rand_block();
        for (int i = 0; i < 16; i++) cur_w[i] = $urandom;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({core_chipselect, core_write, core_address, core_writedata, busy, done, found, error,
             nonce_out, hash_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got cs=%b wr=%b addr=%0d busy=%b done=%b nonce_out=%h count=%0d expected all 0",
                     core_chipselect, core_write, core_address, busy, done, nonce_out, hash_count);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || core_chipselect !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b cs=%b expected 0 0", busy, core_chipselect);
        end
    endtask

    task automatic test_single();
        bit f, to; logic [31:0] nl, cnt; int base;
        rand_block();
        model_sweep('0, 32'd5, 32'd5, f, nl, cnt);
        base = wq.size();
        kick('0, 32'd5, 32'd5);
        wait_idle(300, to);
        checks++; if (to) begin errors++; $display("FAIL single_timeout: busy still %b after budget expected 0", busy); end
        checks++; if (done !== 1'b1 || found !== 1'b0) begin errors++; $display("FAIL single_flags: got done=%b found=%b expected 1 0", done, found); end
        checks++; if (hash_count !== 32'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", hash_count); end
        checks++; if (nonce_out !== 32'd5) begin errors++; $display("FAIL single_nonce_out: got %0d expected 5", nonce_out); end
        checks++; if (wq.size() - base !== 17) begin errors++; $display("FAIL single_writes: got %0d expected 17", wq.size() - base); end
        for (int i = 0; i < eq.size() && base + i < wq.size(); i++) begin
            checks++;
            if (wq[base + i] !== eq[i]) begin errors++; $display("FAIL single_write%0d: got %h expected %h", i, wq[base + i], eq[i]); end
        end
    endtask

    task automatic test_hit();
        bit to; int base; logic [31:0] nws [$];
        rand_block();
        cur_w[0] = 32'd0;
        base = wq.size();
        kick({8{~32'd5}}, 32'd0, 32'd9);
        wait_idle(1500, to);
        checks++; if (to) begin errors++; $display("FAIL hit_timeout: busy still %b after budget expected 0", busy); end
        checks++; if (done !== 1'b1 || found !== 1'b1) begin errors++; $display("FAIL hit_flags: got done=%b found=%b expected 1 1", done, found); end
        checks++; if (nonce_out !== 32'd6) begin errors++; $display("FAIL hit_nonce_out: got %0d expected 6", nonce_out); end
        checks++; if (hash_count !== 32'd7) begin errors++; $display("FAIL hit_count: got %0d expected 7", hash_count); end
        for (int i = base; i < wq.size(); i++)
            if (wq[i][36:32] == 5'(NW)) nws.push_back(wq[i][31:0]);
        checks++; if (nws.size() !== 7) begin errors++; $display("FAIL hit_nonce_writes: got %0d expected 7", nws.size()); end
        for (int i = 0; i < nws.size(); i++) begin
            checks++;
            if (nws[i] !== 32'(i)) begin errors++; $display("FAIL hit_nonce_word%0d: got %0d expected %0d", i, nws[i], i); end
        end
    endtask

    task automatic test_no_wrap();
        bit to; int base;
        rand_block();
        base = wq.size();
        kick('0, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        wait_idle(400, to);
        repeat (100) @(negedge clk);
        checks++; if (to) begin errors++; $display("FAIL wrap_timeout: busy still %b after budget expected 0", busy); end
        checks++; if (hash_count !== 32'd2 || done !== 1'b1) begin errors++; $display("FAIL wrap_count: got count=%0d done=%b expected 2 1", hash_count, done); end
        checks++; if (nonce_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_nonce_out: got %h expected ffffffff", nonce_out); end
        checks++; if (wq.size() - base !== 34) begin errors++; $display("FAIL wrap_writes: got %0d expected 34", wq.size() - base); end
    endtask

    task automatic test_timeout();
        bit to; int wc;
        rand_block();
        hd_en = 1'b0;
        wc = 0;
        kick('0, 32'd1, 32'd3);
        to = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if (core_chipselect && !core_write) wc++;
            if (!busy) begin to = 1'b0; break; end
            @(negedge clk);
        end
        hd_en = 1'b1;
        checks++; if (to) begin errors++; $display("FAIL timeout_bound: busy still %b after budget expected 0", busy); end
        checks++; if (error !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL timeout_flags: got error=%b done=%b expected 1 0", error, done); end
        checks++; if (wc < WMAX || wc > WMAX + 1) begin errors++; $display("FAIL timeout_cycles: got %0d expected %0d..%0d", wc, WMAX, WMAX + 1); end
        checks++; if (core_chipselect !== 1'b0) begin errors++; $display("FAIL timeout_cs: got %b expected 0", core_chipselect); end
    endtask

    task automatic test_abort_and_empty();
        bit to; int base;
        rand_block();
        abort_n = hd_seen + 3;
        kick('0, 32'd0, 32'd9);
        wait_idle(1000, to);
        abort_n = 0;
        checks++; if (to) begin errors++; $display("FAIL abort_timeout: busy still %b after budget expected 0", busy); end
        checks++; if (found !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL abort_flags: got found=%b done=%b error=%b expected 0 0 0", found, done, error); end
        checks++; if (hash_count !== 32'd2) begin errors++; $display("FAIL abort_count: got %0d expected 2", hash_count); end
        checks++; if (core_chipselect !== 1'b0 || core_write !== 1'b0) begin errors++; $display("FAIL abort_bus: got cs=%b wr=%b expected 0 0", core_chipselect, core_write); end
        base = wq.size();
        kick('0, 32'd9, 32'd3);
        repeat (20) @(negedge clk);
        checks++; if (done !== 1'b1 || found !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL empty_flags: got done=%b found=%b busy=%b expected 1 0 0", done, found, busy); end
        checks++; if (hash_count !== 32'd0) begin errors++; $display("FAIL empty_count: got %0d expected 0", hash_count); end
        checks++; if (wq.size() !== base) begin errors++; $display("FAIL empty_writes: got %0d expected 0", wq.size() - base); end
    endtask

    task automatic test_random();
        bit f, to; logic [31:0] nl, cnt, s, e; logic [255:0] tgt; int base, len;
        for (int it = 0; it < 6; it++) begin
            rand_block();
            s   = $urandom;
            len = $urandom_range(0, 3);
            e   = s + 32'(len);
            tgt = digest_of(cur_w[0], s + 32'($urandom_range(0, len + 1)));
            if (it == 5) tgt = '1;
            model_sweep(tgt, s, e, f, nl, cnt);
            base = wq.size();
            kick(tgt, s, e);
            wait_idle(600, to);
            checks++; if (to) begin errors++; $display("FAIL rand%0d_timeout: busy still %b expected 0", it, busy); end
            checks++; if (done !== 1'b1 || found !== f) begin errors++; $display("FAIL rand%0d_flags: got done=%b found=%b expected 1 %b", it, done, found, f); end
            checks++; if (hash_count !== cnt) begin errors++; $display("FAIL rand%0d_count: got %0d expected %0d", it, hash_count, cnt); end
            if (cnt != 0) begin
                checks++; if (nonce_out !== nl) begin errors++; $display("FAIL rand%0d_nonce_out: got %h expected %h", it, nonce_out, nl); end
            end
            checks++; if (wq.size() - base !== eq.size()) begin errors++; $display("FAIL rand%0d_writes: got %0d expected %0d", it, wq.size() - base, eq.size()); end
            for (int i = 0; i < eq.size() && base + i < wq.size(); i++) begin
                checks++;
                if (wq[base + i] !== eq[i]) begin errors++; $display("FAIL rand%0d_write%0d: got %h expected %h", it, i, wq[base + i], eq[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_load();
        bit to; int base;
        rand_block();
        kick('0, 32'd0, 32'd9);
        to = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (core_write && core_address == 5'd7) begin to = 1'b0; break; end
            @(negedge clk);
        end
        checks++; if (to) begin errors++; $display("FAIL midload_reach: address 7 not seen, got %0d expected 7", core_address); end
        reset = 1'b0;
        #1;
        checks++;
        if ({core_chipselect, core_write, core_address, core_writedata, busy, done, found, error,
             nonce_out, hash_count} !== '0) begin
            errors++;
            $display("FAIL midload_outputs: got cs=%b wr=%b addr=%0d data=%h busy=%b nonce_out=%h expected all 0",
                     core_chipselect, core_write, core_address, core_writedata, busy, nonce_out);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        base = wq.size();
        repeat (100) @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midload_idle: got busy=%b done=%b expected 0 0", busy, done); end
        checks++; if (wq.size() !== base) begin errors++; $display("FAIL midload_writes: got %0d expected 0", wq.size() - base); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_hit();
        test_no_wrap();
        test_timeout();
        test_abort_and_empty();
        test_random();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
